alu_result_checker: RTL
=======================

// Module: alu_result_checker
// PURPOSE
//  Response end of the controller->ALU stimulus path. It samples the operands the
//  controller drives (a, b, op) and the ALU's response (res, cf, gt_zero).
//  It recomputes the expected response with an internal reference model and
//  compares the two after a parameterised response latency.
//  It counts passes and fails, and raises done/pass after NUM_VECTORS checks.
// PARAMETERS
//  WIDTH        5  operand/result width
//  NUM_VECTORS  3  checks per run before done
//  RESP_LAT     0  cycles from operand sample to DUT response (0..3)
//  CNT_W        8  width of pass/fail counters
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      1-cycle pulse; clears counters, arms a new run
//  in_valid     in   1      a/b/op are a real vector this cycle
//  a, b         in   WIDTH  operands
//  op           in   1      0 = OR_XOR_AND, 1 = ADD
//  res          in   WIDTH  ALU result, RESP_LAT cycles after its vector
//  cf           in   1      ALU carry flag
//  gt_zero      in   1      ALU nonzero flag
//  pass_cnt     out  CNT_W  matching responses
//  fail_cnt     out  CNT_W  mismatching responses
//  mismatch     out  1      1-cycle pulse, cycle after a failed compare
//  done         out  1      run complete (level)
//  pass         out  1      done && fail_cnt==0
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; delay line valid bits 0.
//  Expected model:
//   op=0: exp_res=(a|b)^(a&b); exp_cf=0.
//   op=1: {exp_cf,exp_res}=a+b, computed at WIDTH+1 bits.
//   exp_gt=|exp_res (unsigned nonzero).
//  FSM states:
//   IDLE: in_valid ignored; start -> RUN.
//   RUN: in_valid pushes {exp,valid} into a RESP_LAT-deep delay line.
//        RESP_LAT=0 compares in the same cycle.
//        Compare when the line's output valid=1. Match = all of res, cf and
//        gt_zero equal the expected values.
//        Pass/fail counter and mismatch update at the next edge.
//        After the NUM_VECTORS-th compare -> DONE.
//   DONE: done=1, pass registered; in_valid ignored; start -> RUN.
//  Vector accounting:
//   - Counts accepted vectors, not compares.
//   - Vectors beyond NUM_VECTORS in RUN are not pushed.
//   - RUN leaves only after their responses drain.
//  start in RUN or DONE:
//   - Clears counters, mismatch, done and pass; flushes the delay line.
//   - Re-enters RUN; that cycle's in_valid is accepted as vector 0.
//  Counters saturate at 2^CNT_W-1 and never wrap.
//  Reset mid-run: immediate return to reset state; no partial results kept.
//  Latency: done rises 1 cycle after the last compare.
// CONFIGURATION
//  CHECKER_CAPTURE_EN defined:
//   - Adds outputs ff_a, ff_b (WIDTH), ff_op, ff_res (WIDTH), ff_idx (CNT_W).
//   - These latch the FIRST failing vector and its index; held until start/reset.
//  Undefined: those ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  Package alu_pkg:
//   - OP_OXA=1'b0, OP_ADD=1'b1.
//   - Default WIDTH=5.
//   - State typedef {IDLE, RUN, DONE}.
//   - Struct exp_t {res, cf, gt}.
//  Sub-module alu_ref_model: combinational (a, b, op) -> exp_t.
//  The delay line and FSM live in this module.
// TESTING
//  1. start; vectors 10101/11011 op0 -> res 01110, cf 0, gt 1; then
//     01101/00011 op1 -> 10000, 0, 1; then 11111/00001 op1 -> 00000, 1, 0.
//     Required: pass_cnt=3, fail_cnt=0, done=1, pass=1.
//  2. Same as 1, but DUT returns res=01111 on vector 2.
//     Required: mismatch pulse, fail_cnt=1, pass=0 at done.
//     With CHECKER_CAPTURE_EN: ff_idx=1, ff_res=01111.
//  3. Vector 3 with cf forced 0 -> fail_cnt=1.
//     Flag-only mismatch is detected (res and gt correct).
//  4. RESP_LAT=2, in_valid gapped 1-0-1-1, responses delayed 2 cycles.
//     Required: 3 passes; done 1 cycle after the last compare.
//  5. start pulsed after 1 vector; then 3 good vectors.
//     Required: counters restart; pass_cnt=3, not 4.
//  6. Reset asserted mid-RUN -> all outputs 0, FSM IDLE.
//     in_valid in IDLE or DONE does not change the counters.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and expected-response record for the ALU checker
package alu_pkg;

  localparam logic OP_OXA = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int DEFAULT_WIDTH = 5;

  // Expected-result field is sized for the widest supported operand; unused upper bits stay zero.
  localparam int EXP_RES_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [EXP_RES_W-1:0] res;
    logic                 cf;
    logic                 gt;
  } exp_t;

endpackage

// File: rtl/alu_result_checker_ref_model.sv
// rtl/alu_result_checker_ref_model.sv - combinational reference ALU producing the expected response
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output exp_t             exp_o
);

  logic [WIDTH:0] sum;

  // Recompute result, carry and nonzero flag for the selected operation
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    if (op_i == OP_ADD) begin
      exp_o.res = EXP_RES_W'(sum[WIDTH-1:0]);
      exp_o.cf  = sum[WIDTH];
    end else begin
      exp_o.res = EXP_RES_W'((a_i | b_i) ^ (a_i & b_i));
      exp_o.cf  = 1'b0;
    end
    exp_o.gt = |exp_o.res;
  end

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - ALU response checker with latency-matched compare and run FSM; CHECKER_CAPTURE_EN adds first-fail capture
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int NUM_VECTORS = 3,
  parameter int RESP_LAT    = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic [WIDTH-1:0] res,
  input  logic             cf,
  input  logic             gt_zero,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic             done,
`ifdef CHECKER_CAPTURE_EN
  output logic             pass,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_op,
  output logic [WIDTH-1:0] ff_res,
  output logic [CNT_W-1:0] ff_idx
`else
  output logic             pass
`endif
);

  localparam int IDX_W = 16;
  localparam int EXP_W = $bits(exp_t);
`ifdef CHECKER_CAPTURE_EN
  localparam int CAP_W = 2 * WIDTH + 1;
`else
  localparam int CAP_W = 0;
`endif
  localparam int LINE_W = 1 + EXP_W + CAP_W;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  acc_q, acc_d, acc_base;
  logic [IDX_W-1:0]  cmp_q, cmp_d, cmp_base;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              mismatch_q, mismatch_d;
  logic              push, cmp_fire, match;
  exp_t              exp_in, exp_out;
  logic [LINE_W-1:0] line_in, line_out;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i  (a),
    .b_i  (b),
    .op_i (op),
    .exp_o(exp_in)
  );

  // A start cycle behaves as the first cycle of a fresh run, so its vector is accepted.
  assign acc_base = start ? '0 : acc_q;
  assign cmp_base = start ? '0 : cmp_q;
  assign push     = in_valid && (start || state_q == RUN) && (acc_base < IDX_W'(NUM_VECTORS));

`ifdef CHECKER_CAPTURE_EN
  logic [CAP_W-1:0] cap_out;
  assign line_in = {push, exp_in, a, b, op};
  assign cap_out = line_out[CAP_W-1:0];
`else
  assign line_in = {push, exp_in};
`endif

  generate
    if (RESP_LAT == 0) begin : g_lat0
      assign line_out = line_in;
    end else begin : g_line
      logic [LINE_W-1:0] stage_q [RESP_LAT];
      // Shift expectations toward the compare point; start drops everything from the old run
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < RESP_LAT; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= line_in;
          for (int i = 1; i < RESP_LAT; i++) stage_q[i] <= start ? '0 : stage_q[i-1];
        end
      end
      assign line_out = stage_q[RESP_LAT-1];
    end
  endgenerate

  assign exp_out  = line_out[LINE_W-2 -: EXP_W];
  assign cmp_fire = line_out[LINE_W-1] && ((RESP_LAT == 0) || !start);
  assign match    = (EXP_RES_W'(res) == exp_out.res) && (cf == exp_out.cf) &&
                    (gt_zero == exp_out.gt);

  // Next run state, saturating pass/fail counters and the mismatch pulse
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_base + IDX_W'(push);
    cmp_d      = cmp_base + IDX_W'(cmp_fire);
    pass_cnt_d = start ? '0 : pass_cnt_q;
    fail_cnt_d = start ? '0 : fail_cnt_q;
    mismatch_d = 1'b0;
    if (start) state_d = RUN;
    if (cmp_fire) begin
      if (match) begin
        if (pass_cnt_d != '1) pass_cnt_d = pass_cnt_d + CNT_W'(1);
      end else begin
        mismatch_d = 1'b1;
        if (fail_cnt_d != '1) fail_cnt_d = fail_cnt_d + CNT_W'(1);
      end
      if (cmp_d == IDX_W'(NUM_VECTORS)) state_d = DONE;
    end
  end

  // Run-control and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cmp_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cmp_q      <= cmp_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign mismatch = mismatch_q;
  assign done     = (state_q == DONE);
  assign pass     = (state_q == DONE) && (fail_cnt_q == '0);

`ifdef CHECKER_CAPTURE_EN
  logic             ff_hit_q;
  logic [WIDTH-1:0] ff_a_q, ff_b_q, ff_res_q;
  logic             ff_op_q;
  logic [CNT_W-1:0] ff_idx_q;

  // Hold the first failing vector of a run; a failure on a start cycle opens the new run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_hit_q <= 1'b0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_op_q  <= 1'b0;
      ff_res_q <= '0;
      ff_idx_q <= '0;
    end else if (cmp_fire && !match && (start || !ff_hit_q)) begin
      ff_hit_q                    <= 1'b1;
      {ff_a_q, ff_b_q, ff_op_q}   <= cap_out;
      ff_res_q                    <= res;
      ff_idx_q                    <= CNT_W'(cmp_base);
    end else if (start) begin
      ff_hit_q <= 1'b0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_op_q  <= 1'b0;
      ff_res_q <= '0;
      ff_idx_q <= '0;
    end
  end

  assign ff_a   = ff_a_q;
  assign ff_b   = ff_b_q;
  assign ff_op  = ff_op_q;
  assign ff_res = ff_res_q;
  assign ff_idx = ff_idx_q;
`endif

endmodule
